// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the bitwise units, the result stage and its consumer.
// slave = the result stage, master = the surrounding logic.
interface alu_result_stage_if #(
  parameter int WIDTH = 8,
  parameter int OP_W  = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [OP_W-1:0]  in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OP_W-1:0]  out_op;
  logic             out_zero;
  logic             out_ones;
  logic             out_parity;

  modport master (
    output in_valid,
    output in_data,
    output in_op,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_op,
    input  out_zero,
    input  out_ones,
    input  out_parity
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_op,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_op,
    output out_zero,
    output out_ones,
    output out_parity
  );
endinterface

// File: rtl/alu_result_stage.sv
// Registered 2-entry skid stage for bitwise-unit results with zero/ones/parity flags.
// Optional transfer statistics counters when RESULT_STATS_EN is defined.
module alu_result_stage #(
  parameter int WIDTH = 8,
  parameter int OP_W  = 3
`ifdef RESULT_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_result_stage_if.slave    bus
`ifdef RESULT_STATS_EN
  ,
  input  logic                 stat_clr,
  output logic [CNT_W-1:0]     stat_count,
  output logic [CNT_W-1:0]     stat_zero
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [OP_W-1:0]  op;
    logic             zero;
    logic             ones;
    logic             parity;
  } entry_t;

  state_t state;
  state_t state_nx;
  entry_t head;
  entry_t skid;
  entry_t cap;

  logic push;
  logic pop;
  logic ld_head_in;
  logic ld_head_skid;
  logic clr_head;
  logic ld_skid;
  logic clr_skid;

  // Flags travel with the entry so the output never re-derives them.
  always_comb begin
    cap.data   = bus.in_data;
    cap.op     = bus.in_op;
    cap.zero   = (bus.in_data == '0);
    cap.ones   = &bus.in_data;
    cap.parity = ^bus.in_data;
  end

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    bus.in_ready  = (state != TWO);
    bus.out_valid = (state != EMPTY);
    ld_head_in    = 1'b0;
    ld_head_skid  = 1'b0;
    clr_head      = 1'b0;
    ld_skid       = 1'b0;
    clr_skid      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (push) begin
          state_nx   = ONE;
          ld_head_in = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          ld_head_in = 1'b1;
        end else if (push) begin
          state_nx = TWO;
          ld_skid  = 1'b1;
        end else if (pop) begin
          state_nx = EMPTY;
          clr_head = 1'b1;
        end
      end
      TWO: begin
        if (pop) begin
          state_nx     = ONE;
          ld_head_skid = 1'b1;
          clr_skid     = 1'b1;
        end
      end
      default: begin
        state_nx = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
    end else begin
      unique case (1'b1)
        ld_head_in:   head <= cap;
        ld_head_skid: head <= skid;
        clr_head:     head <= '0;
        default:      head <= head;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid <= '0;
    end else begin
      unique case (1'b1)
        ld_skid:  skid <= cap;
        clr_skid: skid <= '0;
        default:  skid <= skid;
      endcase
    end
  end

  assign bus.out_data   = head.data;
  assign bus.out_op     = head.op;
  assign bus.out_zero   = head.zero;
  assign bus.out_ones   = head.ones;
  assign bus.out_parity = head.parity;

`ifdef RESULT_STATS_EN
  // Saturating counters; a clear beats a same-cycle transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_count <= '0;
      stat_zero  <= '0;
    end else if (stat_clr) begin
      stat_count <= '0;
      stat_zero  <= '0;
    end else if (pop) begin
      if (stat_count != '1) begin
        stat_count <= stat_count + 1'b1;
      end
      if (head.zero && (stat_zero != '1)) begin
        stat_zero <= stat_zero + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized bench for alu_result_stage against a queue-based reference model.
// Define RESULT_STATS_EN to also exercise the statistics counters.
module tb_alu_result_stage;
  localparam int WIDTH = 8;
  localparam int OP_W  = 3;
`ifdef RESULT_STATS_EN
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
`endif

  typedef struct {
    logic [7:0] d;
    logic [2:0] op;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_result_stage_if #(.WIDTH(WIDTH), .OP_W(OP_W)) bus ();

`ifdef RESULT_STATS_EN
  logic             stat_clr;
  logic [CNT_W-1:0] stat_count;
  logic [CNT_W-1:0] stat_zero;
`endif

  alu_result_stage #(
    .WIDTH(WIDTH),
    .OP_W (OP_W)
`ifdef RESULT_STATS_EN
    ,
    .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
`ifdef RESULT_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stat_count(stat_count),
    .stat_zero (stat_zero)
`endif
  );

  ent_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_push  = 0;
  int   n_pop   = 0;
  int   m_cnt   = 0;
  int   m_zero  = 0;
  bit   taken;
  bit   cur_v;
  bit   cur_r;
  logic [7:0] cur_d;
  logic [2:0] cur_op;
  bit   clr_now = 1'b0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic odd_ones(logic [7:0] d);
    int c;
    c = 0;
    for (int i = 0; i < 8; i++) if (d[i]) c++;
    return (c % 2) == 1;
  endfunction

  task automatic check_outputs(string tag);
    logic [7:0] d;
    check({tag, "_rdy"}, bus.in_ready, q.size() < 2);
    check({tag, "_vld"}, bus.out_valid, q.size() > 0);
    if (q.size() > 0) begin
      d = q[0].d;
      check({tag, "_data"}, bus.out_data, d);
      check({tag, "_op"}, bus.out_op, q[0].op);
      check({tag, "_zero"}, bus.out_zero, d == 8'h00);
      check({tag, "_ones"}, bus.out_ones, d == 8'hFF);
      check({tag, "_par"}, bus.out_parity, odd_ones(d));
    end else begin
      check({tag, "_data"}, bus.out_data, 0);
      check({tag, "_op"}, bus.out_op, 0);
      check({tag, "_flags"},
            {bus.out_zero, bus.out_ones, bus.out_parity}, 0);
    end
`ifdef RESULT_STATS_EN
    check({tag, "_scnt"}, stat_count, m_cnt);
    check({tag, "_szero"}, stat_zero, m_zero);
`endif
  endtask

  // Drive at posedge+1, check against the model at the falling edge.
  task automatic drive(bit v, logic [7:0] d, logic [2:0] op, bit r,
                       string tag);
    cur_v = v; cur_d = d; cur_op = op; cur_r = r;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_op     = op;
    bus.out_ready = r;
`ifdef RESULT_STATS_EN
    stat_clr = clr_now;
`endif
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic advance();
    bit push;
    bit pop;
    bit hz;
    push = cur_v && (q.size() < 2);
    pop  = cur_r && (q.size() > 0);
    hz   = pop && (q[0].d == 8'h00);
    @(posedge clk);
`ifdef RESULT_STATS_EN
    if (clr_now) begin
      m_cnt = 0; m_zero = 0;
    end else if (pop) begin
      if (m_cnt < CMAX) m_cnt++;
      if (hz && m_zero < CMAX) m_zero++;
    end
`else
    if (hz) m_zero++;
`endif
    if (pop) begin
      void'(q.pop_front());
      n_pop++;
    end
    if (push) begin
      q.push_back('{d: cur_d, op: cur_op});
      n_push++;
    end
    taken = push;
    #1;
  endtask

  task automatic step(bit v, logic [7:0] d, logic [2:0] op, bit r,
                      string tag);
    drive(v, d, op, r, tag);
    advance();
  endtask

  initial begin
    int p0;
    int q0;
    bit v;
    logic [7:0] d;
    logic [2:0] op;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_op = '0;
    bus.out_ready = 1'b0;
`ifdef RESULT_STATS_EN
    stat_clr = 1'b0;
`endif
    #1;
    check_outputs("reset0");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // single result
    drive(1, 8'hB5, 3'd5, 1, "t2_push");
    advance();
    drive(0, 8'h00, 3'd0, 1, "t2_out");
    check("t2_vld_k", bus.out_valid, 1);
    check("t2_data_k", bus.out_data, 8'hB5);
    check("t2_op_k", bus.out_op, 5);
    check("t2_flags_k",
          {bus.out_zero, bus.out_ones, bus.out_parity}, 3'b001);
    advance();
    drive(0, 8'h00, 3'd0, 1, "t2_empty");
    check("t2_vld_end", bus.out_valid, 0);
    advance();

    // backpressure
    step(1, 8'h00, 3'd0, 0, "t3_p0");
    step(1, 8'hFF, 3'd1, 0, "t3_p1");
    drive(1, 8'h3C, 3'd2, 0, "t3_p2");
    check("t3_full_rdy", bus.in_ready, 0);
    check("t3_hold_data", bus.out_data, 8'h00);
    check("t3_hold_zero", bus.out_zero, 1);
    advance();
    check("t3_not_taken", taken, 0);
    drive(1, 8'h3C, 3'd2, 1, "t3_d0");
    check("t3_first", bus.out_data, 8'h00);
    advance();
    drive(1, 8'h3C, 3'd2, 1, "t3_d1");
    check("t3_second", bus.out_data, 8'hFF);
    check("t3_ones", {bus.out_ones, bus.out_parity}, 2'b10);
    advance();
    drive(0, 8'h00, 3'd0, 1, "t3_d2");
    check("t3_third", bus.out_data, 8'h3C);
    advance();
    step(0, 8'h00, 3'd0, 1, "t3_idle");

    // streaming
    p0 = n_pop;
    for (int i = 1; i <= 8; i++) begin
      drive(1, 8'(i), 3'(i), 1, "t4_str");
      check("t4_rdy_k", bus.in_ready, 1);
      advance();
    end
    step(0, 8'h00, 3'd0, 1, "t4_drain");
    step(0, 8'h00, 3'd0, 1, "t4_drain");
    check("t4_count", n_pop - p0, 8);

    // random stall
    p0 = n_pop;
    q0 = n_push;
    v = 0;
    d = '0;
    op = '0;
    taken = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!v || taken) begin
        v = ($urandom_range(0, 3) != 0);
        d = 8'($urandom);
        op = 3'($urandom);
      end
      step(v, d, op, $urandom_range(0, 2) != 0, "t5_rnd");
    end
    for (int i = 0; i < 4; i++) step(0, 8'h00, 3'd0, 1, "t5_drain");
    check("t5_balance", n_pop - p0, n_push - q0);

    // reset mid-stream
    step(1, 8'hAA, 3'd3, 0, "t1_fill");
    step(1, 8'h55, 3'd4, 0, "t1_fill");
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    m_cnt = 0;
    m_zero = 0;
    check_outputs("t1_rst");
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    step(0, 8'h00, 3'd0, 1, "t1_after");

`ifdef RESULT_STATS_EN
    for (int i = 0; i < 20; i++) begin
      d = (i == 3 || i == 7 || i == 11) ? 8'h00 : 8'(i + 1);
      step(1, d, 3'(i), 1, "t6_str");
    end
    step(0, 8'h00, 3'd0, 1, "t6_drain");
    step(0, 8'h00, 3'd0, 1, "t6_drain");
    check("t6_count_sat", stat_count, 15);
    check("t6_zero", stat_zero, 3);
    step(1, 8'h00, 3'd0, 1, "t6_push");
    clr_now = 1'b1;
    drive(0, 8'h00, 3'd0, 1, "t6_clr");
    advance();
    clr_now = 1'b0;
    drive(0, 8'h00, 3'd0, 1, "t6_after");
    check("t6_clr_cnt", stat_count, 0);
    check("t6_clr_zero", stat_zero, 0);
    advance();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
